mc_control_fsm: RTL and testbench

Parametrised main control unit for the multicycle MIPS datapath. It holds the instruction-sequencing state machine and drives every datapath enable and mux select from the current state and the opcode: fetch, decode, memory, R-type, branch, immediate-ALU and jump paths. It adds three things: a memory-ready wait handshake, optional extended immediate and branch opcodes, and a sticky illegal-opcode trap. It also keeps a retired-instruction counter for bring-up. It sits between the instruction register (op field) and the datapath, alongside the ALU decoder.

---
 rtl/mc_control_fsm_if.sv | 40 ++++
 rtl/mc_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Signal bundle between the multicycle MIPS control FSM and its datapath.
// master = control unit side, slave = datapath / instruction register side.
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             IorD;
    logic             IRwrite;
    logic             memwrite;
    logic             memtoreg;
    logic             regwrite;
    logic             regdst;
    logic             alusrcA;
    logic             branch;
    logic             pcwrite;
    logic [1:0]       alusrcB;
    logic [2:0]       aluop;
    logic [1:0]       pcsrc;
    logic             zeroext;
    logic             pcen;
    logic             illegal;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, zero, mem_ready,
        output IorD, IRwrite, memwrite, memtoreg, regwrite, regdst, alusrcA,
               branch, pcwrite, alusrcB, aluop, pcsrc, zeroext, pcen, illegal,
               state_o, retired
    );

    modport slave (
        output op, zero, mem_ready,
        input  IorD, IRwrite, memwrite, memtoreg, regwrite, regdst, alusrcA,
               branch, pcwrite, alusrcB, aluop, pcsrc, zeroext, pcen, illegal,
               state_o, retired
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: instruction sequencing,
// memory-ready waits, optional extended opcodes, sticky trap, retired counter.
//
// state   | meaning
// FETCH   | read instruction, PC+4; IR/PC written on mem_ready
// DECODE  | register read, branch target precompute
// MEMADR  | effective address for LW/SW
// MEMRD   | data read, wait for mem_ready
// MEMWB   | load result to rt
// MEMWR   | data write, wait for mem_ready
// EXECUTE | R-type ALU operation
// ALUWB   | R-type result to rd
// BRANCH  | BEQ/BNE compare and conditional PC update
// IMMEXEC | immediate ALU operation
// IMMWB   | immediate result to rt
// JUMP    | PC <- jump target
// TRAP    | illegal opcode, parked until reset
module mc_control_fsm #(
    parameter bit EXT_OPS = 1'b1,
    parameter int CNT_W   = 32
) (
    input logic              clk,
    input logic              reset_n,
    mc_control_fsm_if.master ctrl
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH  = 4'd8,  S_IMMEXEC = 4'd9, S_IMMWB   = 4'd10, S_JUMP  = 4'd11,
        S_TRAP    = 4'd15
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;

    logic       w_iord, w_irwrite, w_memwrite, w_memtoreg, w_regwrite, w_regdst;
    logic       w_alusrca, w_branch, w_pcwrite, w_zeroext;
    logic [1:0] w_alusrcb, w_pcsrc;
    logic [2:0] w_aluop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_iord     = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_alusrca  = 1'b0;
        w_branch   = 1'b0;
        w_pcwrite  = 1'b0;
        w_zeroext  = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        w_aluop    = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = ctrl.mem_ready;
                w_pcwrite = ctrl.mem_ready;
                if (ctrl.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (ctrl.op)
                    OP_RTYPE:                   w_next = S_EXECUTE;
                    OP_LW, OP_SW:               w_next = S_MEMADR;
                    OP_BEQ:                     w_next = S_BRANCH;
                    OP_ADDI:                    w_next = S_IMMEXEC;
                    OP_J:                       w_next = S_JUMP;
                    OP_BNE:                     w_next = EXT_OPS ? S_BRANCH : S_TRAP;
                    OP_ANDI, OP_ORI, OP_SLTI:   w_next = EXT_OPS ? S_IMMEXEC : S_TRAP;
                    default:                    w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (ctrl.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (ctrl.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                if (ctrl.mem_ready) w_next = S_FETCH;
            end
            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = 3'b010;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 3'b001;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
                w_next    = S_FETCH;
            end
            S_IMMEXEC: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                case (ctrl.op)
                    OP_ANDI: w_aluop = 3'b011;
                    OP_ORI:  w_aluop = 3'b100;
                    OP_SLTI: w_aluop = 3'b101;
                    default: w_aluop = 3'b000;
                endcase
                w_zeroext = (ctrl.op == OP_ANDI) || (ctrl.op == OP_ORI);
                w_next    = S_IMMWB;
            end
            S_IMMWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    // An instruction retires on the edge that returns to FETCH; TRAP never returns.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end

    assign ctrl.IorD     = w_iord;
    assign ctrl.IRwrite  = w_irwrite;
    assign ctrl.memwrite = w_memwrite;
    assign ctrl.memtoreg = w_memtoreg;
    assign ctrl.regwrite = w_regwrite;
    assign ctrl.regdst   = w_regdst;
    assign ctrl.alusrcA  = w_alusrca;
    assign ctrl.branch   = w_branch;
    assign ctrl.pcwrite  = w_pcwrite;
    assign ctrl.alusrcB  = w_alusrcb;
    assign ctrl.aluop    = w_aluop;
    assign ctrl.pcsrc    = w_pcsrc;
    assign ctrl.zeroext  = w_zeroext;
    assign ctrl.pcen     = w_pcwrite | (w_branch & (ctrl.zero ^ (ctrl.op == OP_BNE)));
    assign ctrl.illegal  = (r_state == S_TRAP);
    assign ctrl.state_o  = r_state;
    assign ctrl.retired  = r_retired;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction table, hand-written wait/reset/trap/wrap
// sequences, and random instruction streams against an instruction-level model.
module tb_mc_control_fsm;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010,
                           OP_J = 6'b000010;

    logic clk = 1'b0;
    logic reset_n;
    logic reset_n2;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(32)) bus ();
    mc_control_fsm_if #(.CNT_W(4))  bus2 ();

    mc_control_fsm #(.EXT_OPS(1'b1), .CNT_W(32)) dut (.clk(clk), .reset_n(reset_n), .ctrl(bus));
    mc_control_fsm #(.EXT_OPS(1'b0), .CNT_W(4))  dut2 (.clk(clk), .reset_n(reset_n2), .ctrl(bus2));

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic iord, irw, memw, m2r, regw, regdst, srca, branch, pcw;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic zext, illegal;
    } ctl_t;

    function automatic ctl_t get_ctl();
        ctl_t c;
        c = {bus.IorD, bus.IRwrite, bus.memwrite, bus.memtoreg, bus.regwrite, bus.regdst,
             bus.alusrcA, bus.branch, bus.pcwrite, bus.alusrcB, bus.aluop, bus.pcsrc,
             bus.zeroext, bus.illegal};
        return c;
    endfunction

    // Control word each state must present, straight from the state descriptions.
    function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic mr);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
            1:  c.srcb = 2'b11;
            2:  begin c.srca = 1; c.srcb = 2'b10; end
            3:  c.iord = 1;
            4:  begin c.m2r = 1; c.regw = 1; end
            5:  begin c.iord = 1; c.memw = 1; end
            6:  begin c.srca = 1; c.aluop = 3'b010; end
            7:  begin c.regdst = 1; c.regw = 1; end
            8:  begin c.srca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branch = 1; end
            9:  begin
                c.srca = 1; c.srcb = 2'b10;
                c.aluop = (op == OP_ANDI) ? 3'b011 : (op == OP_ORI) ? 3'b100 :
                          (op == OP_SLTI) ? 3'b101 : 3'b000;
                c.zext = (op == OP_ANDI) || (op == OP_ORI);
            end
            10: c.regw = 1;
            11: begin c.pcsrc = 2'b10; c.pcw = 1; end
            default: c.illegal = 1;
        endcase
        return c;
    endfunction

    function automatic logic exp_pcen(input int st, input logic [5:0] op, input logic mr, input logic z);
        if (st == 0)  return mr;
        if (st == 11) return 1'b1;
        if (st == 8)  return (op == OP_BNE) ? !z : z;
        return 1'b0;
    endfunction

    typedef int q_t[$];
    function automatic q_t path_of(input logic [5:0] op);
        q_t p;
        case (op)
            OP_RTYPE:                         p = {0, 1, 6, 7};
            OP_LW:                            p = {0, 1, 2, 3, 4};
            OP_SW:                            p = {0, 1, 2, 5};
            OP_BEQ, OP_BNE:                   p = {0, 1, 8};
            OP_J:                             p = {0, 1, 11};
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: p = {0, 1, 9, 10};
            default:                          p = {0, 1, 15};
        endcase
        return p;
    endfunction

    // Runs one instruction from FETCH with mem_ready=1 until FETCH comes back.
    task automatic run_instr(input logic [5:0] op, input logic z, output int len, output int pulses,
                             output logic [3:0] st2, output logic [2:0] alu2, output logic zx2);
        len = 0; pulses = 0; st2 = 0; alu2 = 0; zx2 = 0;
        bus.op = op; bus.zero = z; bus.mem_ready = 1'b1;
        #1;
        do begin
            if (bus.pcen) pulses++;
            if (len == 2) begin st2 = bus.state_o; alu2 = bus.aluop; zx2 = bus.zeroext; end
            len++;
            @(posedge clk); #1;
        end while (bus.state_o != 4'd0 && len < 40);
    endtask

    typedef struct {
        logic [5:0] op; logic zero; int len; int pulses;
        logic [3:0] st2; logic [2:0] alu2; logic zx2;
    } vec_t;
    vec_t vecs[12];

    logic [5:0] legal[10] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J};
    logic       mr_seq[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    initial begin
        int len, pulses, exp_ret, cnt_ir, cnt_pcw, cnt_iord, ir_idx;
        logic [3:0] st2;
        logic [2:0] alu2;
        logic zx2;

        vecs[0]  = '{OP_RTYPE, 1'b0, 4, 1, 4'd6, 3'b010, 1'b0};
        vecs[1]  = '{OP_LW,    1'b0, 5, 1, 4'd2, 3'b000, 1'b0};
        vecs[2]  = '{OP_SW,    1'b0, 4, 1, 4'd2, 3'b000, 1'b0};
        vecs[3]  = '{OP_BEQ,   1'b1, 3, 2, 4'd8, 3'b001, 1'b0};
        vecs[4]  = '{OP_J,     1'b0, 3, 2, 4'd11, 3'b000, 1'b0};
        vecs[5]  = '{OP_ADDI,  1'b0, 4, 1, 4'd9, 3'b000, 1'b0};
        vecs[6]  = '{OP_BNE,   1'b0, 3, 2, 4'd8, 3'b001, 1'b0};
        vecs[7]  = '{OP_BNE,   1'b1, 3, 1, 4'd8, 3'b001, 1'b0};
        vecs[8]  = '{OP_BEQ,   1'b0, 3, 1, 4'd8, 3'b001, 1'b0};
        vecs[9]  = '{OP_ORI,   1'b0, 4, 1, 4'd9, 3'b100, 1'b1};
        vecs[10] = '{OP_ANDI,  1'b0, 4, 1, 4'd9, 3'b011, 1'b1};
        vecs[11] = '{OP_SLTI,  1'b1, 4, 1, 4'd9, 3'b101, 1'b0};

        reset_n = 1'b0; reset_n2 = 1'b0;
        bus.op = OP_RTYPE; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        bus2.op = OP_J; bus2.zero = 1'b0; bus2.mem_ready = 1'b1;
        #1;
        check("rst_state", bus.state_o, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_ctl_mr0", get_ctl(), exp_ctl(0, OP_RTYPE, 1'b0));
        bus.mem_ready = 1'b1; #1;
        check("rst_ctl_mr1", get_ctl(), exp_ctl(0, OP_RTYPE, 1'b1));
        check("rst_pcen", bus.pcen, 1);
        @(posedge clk); #1; reset_n = 1'b1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].zero, len, pulses, st2, alu2, zx2);
            check($sformatf("tbl%0d_len", i), len, vecs[i].len);
            check($sformatf("tbl%0d_pcen", i), pulses, vecs[i].pulses);
            check($sformatf("tbl%0d_state", i), st2, vecs[i].st2);
            check($sformatf("tbl%0d_aluop", i), alu2, vecs[i].alu2);
            check($sformatf("tbl%0d_zeroext", i), zx2, vecs[i].zx2);
            check($sformatf("tbl%0d_retired", i), bus.retired, i + 1);
        end

        // LW with 3 FETCH wait cycles and 2 MEMRD wait cycles: 10 cycles total.
        bus.op = OP_LW; cnt_ir = 0; cnt_pcw = 0; cnt_iord = 0; ir_idx = -1;
        for (int c = 0; c < 10; c++) begin
            bus.mem_ready = mr_seq[c]; #1;
            if (bus.IRwrite) begin cnt_ir++; ir_idx = c; end
            if (bus.pcwrite) cnt_pcw++;
            if (bus.IorD) cnt_iord++;
            if (c == 9) check("lwwait_memwb", bus.state_o, 4);
            @(posedge clk); #1;
        end
        check("lwwait_done", bus.state_o, 0);
        check("lwwait_irwrite_cnt", cnt_ir, 1);
        check("lwwait_irwrite_idx", ir_idx, 3);
        check("lwwait_pcwrite_cnt", cnt_pcw, 1);
        check("lwwait_iord_cnt", cnt_iord, 3);
        check("lwwait_retired", bus.retired, 13);

        // Asynchronous reset in the middle of a MEMWR wait.
        bus.op = OP_SW; bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        check("swrst_state_before", bus.state_o, 5);
        check("swrst_memwrite_before", bus.memwrite, 1);
        #3; reset_n = 1'b0; #1;
        check("swrst_memwrite", bus.memwrite, 0);
        check("swrst_state", bus.state_o, 0);
        check("swrst_retired", bus.retired, 0);
        @(posedge clk); #1; reset_n = 1'b1;

        exp_ret = 0;
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op_r;
            q_t p;
            int idx;
            op_r = legal[$urandom_range(0, 9)];
            p = path_of(op_r);
            bus.op = op_r;
            idx = 0;
            while (idx < p.size()) begin
                logic mr, z;
                mr = ($urandom_range(0, 3) != 0);
                z = 1'($urandom_range(0, 1));
                bus.mem_ready = mr; bus.zero = z; #1;
                check("rnd_state", bus.state_o, p[idx]);
                check("rnd_ctl", get_ctl(), exp_ctl(p[idx], op_r, mr));
                check("rnd_pcen", bus.pcen, exp_pcen(p[idx], op_r, mr, z));
                check("rnd_retired", bus.retired, exp_ret);
                if (!((p[idx] == 0 || p[idx] == 3 || p[idx] == 5) && !mr)) idx++;
                if (idx == p.size()) exp_ret++;
                @(posedge clk); #1;
            end
        end

        bus.op = 6'b111111; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("badop_state", bus.state_o, 15);
        check("badop_illegal", bus.illegal, 1);
        check("badop_ctl", get_ctl(), exp_ctl(15, 6'b111111, 1'b1));
        reset_n = 1'b0; #1;
        check("badop_rst_illegal", bus.illegal, 0);
        @(posedge clk); #1; reset_n = 1'b1;

        // EXT_OPS=0, CNT_W=4 instance: counter wrap, then ORI traps.
        reset_n2 = 1'b1;
        repeat (48) @(posedge clk);
        #1;
        check("wrap16_retired", bus2.retired, 0);
        check("wrap16_state", bus2.state_o, 0);
        repeat (3) @(posedge clk);
        #1;
        check("wrap17_retired", bus2.retired, 1);
        bus2.op = OP_ORI;
        repeat (2) @(posedge clk);
        #1;
        check("noext_trap_state", bus2.state_o, 15);
        check("noext_trap_illegal", bus2.illegal, 1);
        for (int k = 0; k < 20; k++) begin
            bus2.op = 6'($urandom_range(0, 63));
            bus2.zero = 1'($urandom_range(0, 1));
            bus2.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("trap_hold_illegal", bus2.illegal, 1);
            check("trap_hold_retired", bus2.retired, 1);
            check("trap_hold_pcen", bus2.pcen, 0);
        end
        reset_n2 = 1'b0; #1;
        check("trap_rst_illegal", bus2.illegal, 0);
        check("trap_rst_retired", bus2.retired, 0);
        check("trap_rst_state", bus2.state_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
